gray_decoder: RTL and testbench

GRAY_DECODER -- requirements
Module: gray_decoder

---
 rtl/gray_pkg.sv | 14 +
 rtl/gray2bin.sv | 23 ++
 rtl/gray_decoder.sv | 108 ++++++++++
 tb/tb_gray_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants and state encoding for the Gray decoder
package gray_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int WRAP_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2,
    RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray to binary conversion
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    acc = 1'b0;
    bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - sampled Gray counter decoder with step checking and resync
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  Gray,
  output logic [WIDTH-1:0]  Binary,
  output logic              Valid,
  output logic              Overflow,
  output logic              StepErr,
  output logic [WRAP_W-1:0] WrapCount
);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  dec;
  logic [WIDTH-1:0]  ref_q, ref_d, ref_inc;
  logic [WIDTH-1:0]  cand_q, cand_d, cand_inc;
  logic [WIDTH-1:0]  bin_d;
  logic [WRAP_W-1:0] wrap_d;
  logic              ovf_d, err_d;
  logic              ref_hold, ref_fwd, cand_ok;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (Gray),
    .bin  (dec)
  );

  // Increments are kept at WIDTH bits so the modulo wrap is implicit.
  assign ref_inc  = ref_q + WIDTH'(1);
  assign cand_inc = cand_q + WIDTH'(1);
  assign ref_hold = (dec == ref_q);
  assign ref_fwd  = (dec == ref_inc);
  assign cand_ok  = (dec == cand_q) || (dec == cand_inc);

  assign Valid = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    ref_d     = ref_q;
    cand_d    = cand_q;
    bin_d     = Binary;
    wrap_d    = WrapCount;
    ovf_d     = 1'b0;
    err_d     = 1'b0;
    if (En) begin
      case (state)
        IDLE: begin
          ref_d     = dec;
          bin_d     = dec;
          state_nxt = LOCKED;
        end
        LOCKED: begin
          if (ref_fwd) begin
            ref_d = dec;
            bin_d = dec;
            if (&ref_q) begin
              ovf_d  = 1'b1;
              wrap_d = (&WrapCount) ? WrapCount : WrapCount + WRAP_W'(1);
            end
          end else if (!ref_hold) begin
            err_d     = 1'b1;
            state_nxt = FAULT;
          end
        end
        FAULT: begin
          cand_d    = dec;
          state_nxt = RESYNC;
        end
        RESYNC: begin
          // A wrap seen while relocking is not counted as an overflow.
          if (cand_ok) begin
            ref_d     = dec;
            bin_d     = dec;
            state_nxt = LOCKED;
          end else begin
            cand_d = dec;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      ref_q     <= '0;
      cand_q    <= '0;
      Binary    <= '0;
      WrapCount <= '0;
      Overflow  <= 1'b0;
      StepErr   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ref_q     <= ref_d;
      cand_q    <= cand_d;
      Binary    <= bin_d;
      WrapCount <= wrap_d;
      Overflow  <= ovf_d;
      StepErr   <= err_d;
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - table-driven and sequence checks for gray_decoder
module tb_gray_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] gray;
  logic [2:0] binary;
  logic       valid;
  logic       ovf;
  logic       err;
  logic [3:0] wrap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] gray;
    logic [2:0] bin;
    logic       valid;
    logic       ovf;
    logic       err;
    logic [3:0] wrap;
  } vec_t;

  vec_t vecs[$];

  gray_decoder #(.WIDTH(3)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .En        (en),
    .Gray      (gray),
    .Binary    (binary),
    .Valid     (valid),
    .Overflow  (ovf),
    .StepErr   (err),
    .WrapCount (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got time %0t want < 500000", $time);
    $fatal(1, "timeout");
  end

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic apply(input logic r, input logic e, input logic [2:0] g);
    rst  = r;
    en   = e;
    gray = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got bin/v/ovf/err/wrap=%b want %b", name, got, want);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic [2:0] g,
                              input logic [2:0] b, input logic v, input logic o,
                              input logic s, input logic [3:0] w);
    vec_t t;
    t.rst = r; t.en = e; t.gray = g; t.bin = b;
    t.valid = v; t.ovf = o; t.err = s; t.wrap = w;
    vecs.push_back(t);
  endfunction

  function automatic logic [2:0] to_gray(input int n);
    logic [2:0] b;
    b = 3'(n);
    return b ^ (b >> 1);
  endfunction

  initial begin
    int ovf_seen;
    rst = 1'b1; en = 1'b0; gray = 3'b000;
    @(negedge clk);

    // reset and the plain upward count with one wrap
    add(1,0,3'b000, 0,0,0,0,0);
    add(1,0,3'b000, 0,0,0,0,0);
    add(0,1,3'b000, 0,1,0,0,0);
    add(0,1,3'b001, 1,1,0,0,0);
    add(0,1,3'b011, 2,1,0,0,0);
    add(0,1,3'b010, 3,1,0,0,0);
    add(0,1,3'b110, 4,1,0,0,0);
    add(0,1,3'b111, 5,1,0,0,0);
    add(0,1,3'b101, 6,1,0,0,0);
    add(0,1,3'b100, 7,1,0,0,0);
    add(0,1,3'b000, 0,1,1,0,1);
    add(0,1,3'b000, 0,1,0,0,1);
    add(0,0,3'b101, 0,1,0,0,1);
    // forward jump to 6 from 3, then relock at 6
    add(0,1,3'b001, 1,1,0,0,1);
    add(0,1,3'b011, 2,1,0,0,1);
    add(0,1,3'b010, 3,1,0,0,1);
    add(0,1,3'b101, 3,0,0,1,1);
    add(0,1,3'b111, 3,0,0,0,1);
    add(0,1,3'b101, 6,1,0,0,1);
    // backward steps, relock on HOLD, illegal while resyncing
    add(0,1,3'b111, 6,0,0,1,1);
    add(0,1,3'b111, 6,0,0,0,1);
    add(0,1,3'b111, 5,1,0,0,1);
    add(0,1,3'b110, 5,0,0,1,1);
    add(0,1,3'b110, 5,0,0,0,1);
    add(0,1,3'b000, 5,0,0,0,1);
    add(0,1,3'b001, 1,1,0,0,1);
    // reset with En high at Binary=6 discards the sample
    add(0,1,3'b011, 2,1,0,0,1);
    add(0,1,3'b010, 3,1,0,0,1);
    add(0,1,3'b110, 4,1,0,0,1);
    add(0,1,3'b111, 5,1,0,0,1);
    add(0,1,3'b101, 6,1,0,0,1);
    add(1,1,3'b100, 0,0,0,0,0);
    add(0,1,3'b011, 2,1,0,0,0);
    // relock across a wrap gives no overflow
    add(0,1,3'b000, 2,0,0,1,0);
    add(0,1,3'b100, 2,0,0,0,0);
    add(0,1,3'b000, 0,1,0,0,0);
    add(0,0,3'b001, 0,1,0,0,0);
    add(0,1,3'b001, 1,1,0,0,0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].gray);
      check($sformatf("vec%0d", i), {binary, valid, ovf, err, wrap},
            {vecs[i].bin, vecs[i].valid, vecs[i].ovf, vecs[i].err, vecs[i].wrap});
    end

    // En toggling: only enabled edges advance, single overflow
    apply(1, 0, 3'b000);
    apply(1, 0, 3'b000);
    ovf_seen = 0;
    for (int k = 0; k <= 8; k++) begin
      apply(0, 1, to_gray(k));
      if (ovf) ovf_seen++;
      check($sformatf("entog_on%0d", k), {binary, valid, err}, {3'(k), 1'b1, 1'b0});
      apply(0, 0, ~to_gray(k));
      if (ovf) ovf_seen++;
      check($sformatf("entog_off%0d", k), {binary, valid, ovf, err}, {3'(k), 1'b1, 1'b0, 1'b0});
    end
    check("entog_ovf_count", 10'(ovf_seen), 10'd1);
    check("entog_wrap", 10'(wrap), 10'd1);

    // many wraps: counter saturates, overflow keeps pulsing
    apply(1, 0, 3'b000);
    apply(0, 1, 3'b000);
    for (int w = 1; w <= 17; w++) begin
      for (int k = 1; k <= 8; k++) begin
        apply(0, 1, to_gray(k));
        if (k == 8)
          check($sformatf("sat_wrap%0d", w), {binary, valid, ovf, err, wrap},
                {3'd0, 1'b1, 1'b1, 1'b0, 4'((w > 15) ? 15 : w)});
        else if (ovf || err) begin
          total++;
          bad++;
          $display("FAIL sat_pulse w%0d k%0d: got ovf=%b err=%b want 0 0", w, k, ovf, err);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
